// File: rtl/sram_rr_arbiter_pkg.sv
// Shared types for the SRAM round-robin arbiter: the response-tracking
// pipeline entry that follows a read from grant to read-data return.
package sram_rr_arbiter_pkg;

    // Wide enough for the largest supported requester count (8).
    localparam int RSP_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [RSP_ID_W-1:0] id;
    } rsp_stage_t;

    localparam rsp_stage_t RSP_STAGE_IDLE = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: the first valid requester at or above
// ptr (wrapping mod NUM_REQ) wins.
module sram_rr_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    // Scan offsets farthest-first so the nearest valid requester to ptr is the last assignment and wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (valid[ID_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters.
// The winning command is registered onto the SRAM pins; read data returns to
// the issuing requester two cycles after acceptance.
module sram_rr_arbiter
    import sram_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int REQ_ID_WIDTH     = 2,
    parameter int BYTE             = 8,
    parameter int NUM_BYTE_IN_WORD = 64,
    parameter int ADDR_WIDTH       = 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ*NUM_BYTE_IN_WORD-1:0]  req_byteena,
    input  logic [NUM_REQ*BYTE*NUM_BYTE_IN_WORD-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [BYTE*NUM_BYTE_IN_WORD-1:0]     rsp_rdata,
    output logic [ADDR_WIDTH-1:0]                sram_address,
    output logic [NUM_BYTE_IN_WORD-1:0]          sram_byteena,
    output logic [BYTE*NUM_BYTE_IN_WORD-1:0]     sram_data,
    output logic                                 sram_rden,
    output logic                                 sram_wren,
    input  logic [BYTE*NUM_BYTE_IN_WORD-1:0]     sram_q,
    output logic                                 busy
);

    localparam int WORD_W = BYTE * NUM_BYTE_IN_WORD;

    logic                        grant_valid;
    logic [REQ_ID_WIDTH-1:0]     grant_id;
    logic                        grant_fire;

    logic                        sel_we;
    logic [ADDR_WIDTH-1:0]       sel_addr;
    logic [NUM_BYTE_IN_WORD-1:0] sel_be;
    logic [WORD_W-1:0]           sel_wdata;

    logic [REQ_ID_WIDTH-1:0]     ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [NUM_BYTE_IN_WORD-1:0] be_q, be_d;
    logic [WORD_W-1:0]           data_q, data_d;
    logic                        rden_q, rden_d;
    logic                        wren_q, wren_d;
    rsp_stage_t                  s1_q, s1_d;
    rsp_stage_t                  s2_q, s2_d;

    sram_rr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (REQ_ID_WIDTH)
    ) u_pick (
        .valid       (req_valid),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // No grants are issued while reset is held.
    assign grant_fire = grant_valid & ~rst;

    // Select the winning requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == REQ_ID_WIDTH'(k)) begin
                sel_we    = req_we[k];
                sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_be    = req_byteena[k*NUM_BYTE_IN_WORD +: NUM_BYTE_IN_WORD];
                sel_wdata = req_wdata[k*WORD_W +: WORD_W];
            end
        end
    end

    // One-hot ready to the winner.
    always_comb begin
        req_ready = '0;
        if (grant_fire) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next state: rotate ptr past the winner, load the SRAM command, advance the read tracker.
    always_comb begin
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        be_d      = be_q;
        data_d    = data_q;
        rden_d    = 1'b0;
        wren_d    = 1'b0;
        s1_d      = RSP_STAGE_IDLE;
        s2_d      = s1_q;
        if (grant_fire) begin
            ptr_d  = (grant_id == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            addr_d = sel_addr;
            be_d   = sel_we ? sel_be : '1;
            data_d = sel_wdata;
            rden_d = ~sel_we;
            wren_d = sel_we;
            s1_d.valid = ~sel_we;
            s1_d.id    = RSP_ID_W'(grant_id);
        end
    end

    // State registers with synchronous reset; reset also drops any reads in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            addr_q <= '0;
            be_q   <= '0;
            data_q <= '0;
            rden_q <= 1'b0;
            wren_q <= 1'b0;
            s1_q   <= RSP_STAGE_IDLE;
            s2_q   <= RSP_STAGE_IDLE;
        end else begin
            ptr_q  <= ptr_d;
            addr_q <= addr_d;
            be_q   <= be_d;
            data_q <= data_d;
            rden_q <= rden_d;
            wren_q <= wren_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
        end
    end

    // Decode the second tracker stage into the response strobe for its owner.
    always_comb begin
        rsp_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rsp_valid[k] = ~rst & s2_q.valid & (s2_q.id == RSP_ID_W'(k));
        end
    end

    assign rsp_rdata    = sram_q;
    assign sram_address = addr_q;
    assign sram_byteena = be_q;
    assign sram_data    = data_q;
    assign sram_rden    = rden_q;
    assign sram_wren    = wren_q;
    assign busy         = (|req_valid) | s1_q.valid | s2_q.valid | rden_q | wren_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Scoreboard bench for sram_rr_arbiter with a behavioural SRAM and a
// reference memory updated in grant order.
module tb_sram_rr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int AW  = 7;
    localparam int NB  = 64;
    localparam int W   = 8 * NB;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_we = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*NB-1:0]   req_byteena = '0;
    logic [N*W-1:0]    req_wdata = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [W-1:0]      rsp_rdata;
    logic [AW-1:0]     sram_address;
    logic [NB-1:0]     sram_byteena;
    logic [W-1:0]      sram_data;
    logic              sram_rden;
    logic              sram_wren;
    logic [W-1:0]      sram_q = '0;
    logic              busy;

    always #5 clk = ~clk;

    sram_rr_arbiter #(
        .NUM_REQ(N), .REQ_ID_WIDTH(IDW), .BYTE(8), .NUM_BYTE_IN_WORD(NB), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_byteena(req_byteena), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_address(sram_address), .sram_byteena(sram_byteena), .sram_data(sram_data),
        .sram_rden(sram_rden), .sram_wren(sram_wren), .sram_q(sram_q), .busy(busy)
    );

    // Behavioural single-port SRAM: registered read, byte-enabled write.
    logic [W-1:0] sram_mem [1 << AW];
    always @(posedge clk) begin
        if (sram_wren)
            for (int b = 0; b < NB; b++)
                if (sram_byteena[b]) sram_mem[sram_address][b*8 +: 8] <= sram_data[b*8 +: 8];
        if (sram_rden) sram_q <= sram_mem[sram_address];
    end

    typedef struct {
        bit           we;
        logic [AW-1:0] addr;
        logic [NB-1:0] be;
        logic [W-1:0]  wdata;
    } cmd_t;

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           cyc;
    } rsp_t;

    cmd_t         cmdq [N][$];
    cmd_t         cur_cmd [N];
    rsp_t         expq [$];
    int           gseq [$];
    logic [W-1:0] ref_mem [1 << AW];
    int           issued [N];
    int           granted [N];
    int           waitc [N];
    logic [N-1:0] hs = '0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           mptr = 0;
    bit           prev_grant = 0;
    cmd_t         prev_cmd;
    int           last_grant_cyc = -100;
    int           last_read_cyc = -100;
    logic [W-1:0] last_rdata = '0;
    logic [N-1:0] last_rsp_valid = '0;
    bit           gaps = 0;

    task automatic check(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [W-1:0] be_mask(input logic [NB-1:0] be);
        logic [W-1:0] m;
        for (int b = 0; b < NB; b++) m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction

    // Monitor: SRAM pins, arbitration order, busy and responses against the reference model.
    always @(negedge clk) begin
        logic [N-1:0] oh;
        bit           busy_exp;
        int           w;
        rsp_t         e;
        cyc++;
        if (prev_grant) begin
            check(sram_rden == !prev_cmd.we, "sram_rden", W'(sram_rden), W'(!prev_cmd.we));
            check(sram_wren == prev_cmd.we, "sram_wren", W'(sram_wren), W'(prev_cmd.we));
            check(sram_address == prev_cmd.addr, "sram_address", W'(sram_address), W'(prev_cmd.addr));
            if (prev_cmd.we) begin
                check(sram_byteena == prev_cmd.be, "sram_byteena_wr", W'(sram_byteena), W'(prev_cmd.be));
                check(sram_data == prev_cmd.wdata, "sram_data", sram_data, prev_cmd.wdata);
            end else begin
                check(sram_byteena == {NB{1'b1}}, "sram_byteena_rd", W'(sram_byteena), W'({NB{1'b1}}));
            end
        end else begin
            check(!sram_rden && !sram_wren, "sram_idle", W'({sram_rden, sram_wren}), '0);
        end
        prev_grant = 0;
        if (rst) begin
            check(req_ready == '0, "ready_in_reset", W'(req_ready), '0);
            check(rsp_valid == '0, "rsp_in_reset", W'(rsp_valid), '0);
            expq.delete();
            mptr = 0;
            hs = '0;
            last_grant_cyc = -100;
            last_read_cyc = -100;
            for (int k = 0; k < N; k++) waitc[k] = 0;
        end else begin
            busy_exp = (req_valid != '0) || (cyc - last_grant_cyc == 1) || (cyc - last_read_cyc == 2);
            check(busy == busy_exp, "busy", W'(busy), W'(busy_exp));
            if (rsp_valid != '0) begin
                if (expq.size() == 0) begin
                    check(0, "rsp_unexpected", W'(rsp_valid), '0);
                end else begin
                    e = expq.pop_front();
                    oh = N'(1) << e.id;
                    check(rsp_valid == oh, "rsp_owner", W'(rsp_valid), W'(oh));
                    check(rsp_rdata == e.data, "rsp_data", rsp_rdata, e.data);
                    check(cyc == e.cyc, "rsp_latency", W'(cyc), W'(e.cyc));
                    last_rdata = rsp_rdata;
                    last_rsp_valid = rsp_valid;
                end
            end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                check(0, "rsp_missing", '0, W'(expq[0].id));
                void'(expq.pop_front());
            end
            hs = req_valid & req_ready;
            if (req_valid != '0) begin
                w = -1;
                for (int i = N - 1; i >= 0; i--)
                    if (req_valid[(mptr + i) % N]) w = (mptr + i) % N;
                oh = N'(1) << w;
                check(req_ready == oh, "grant", W'(req_ready), W'(oh));
                for (int k = 0; k < N; k++)
                    if (req_ready[k]) gseq.push_back(k);
                granted[w]++;
                prev_grant = 1;
                prev_cmd = cur_cmd[w];
                last_grant_cyc = cyc;
                if (cur_cmd[w].we) begin
                    ref_mem[cur_cmd[w].addr] = (ref_mem[cur_cmd[w].addr] & ~be_mask(cur_cmd[w].be))
                                             | (cur_cmd[w].wdata & be_mask(cur_cmd[w].be));
                end else begin
                    expq.push_back('{id: w, data: ref_mem[cur_cmd[w].addr], cyc: cyc + 2});
                    last_read_cyc = cyc;
                end
                mptr = (w + 1) % N;
            end else begin
                check(req_ready == '0, "ready_idle", W'(req_ready), '0);
            end
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && !req_ready[k]) begin
                    waitc[k]++;
                    check(waitc[k] <= N - 1, "wait_bound", W'(waitc[k]), W'(N - 1));
                end else begin
                    waitc[k] = 0;
                end
            end
        end
    end

    task automatic push_cmd(input int k, input bit we, input int addr, input logic [NB-1:0] be, input logic [W-1:0] d);
        cmd_t c;
        c.we = we;
        c.addr = AW'(addr);
        c.be = be;
        c.wdata = d;
        cmdq[k].push_back(c);
        issued[k]++;
    endtask

    // Advance one cycle; a requester loads its next command once the previous one was accepted.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (!req_valid[k] || hs[k]) begin
                if (cmdq[k].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    cur_cmd[k] = cmdq[k].pop_front();
                    req_valid[k] = 1'b1;
                    req_we[k] = cur_cmd[k].we;
                    req_addr[k*AW +: AW] = cur_cmd[k].addr;
                    req_byteena[k*NB +: NB] = cur_cmd[k].be;
                    req_wdata[k*W +: W] = cur_cmd[k].wdata;
                end else begin
                    req_valid[k] = 1'b0;
                end
            end
        end
    endtask

    function automatic bit idle();
        bit r;
        r = (req_valid == '0) && (expq.size() == 0);
        for (int k = 0; k < N; k++) if (cmdq[k].size() != 0) r = 0;
        return r;
    endfunction

    task automatic run(input int max_cycles);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!idle() && n < max_cycles);
        if (!idle()) check(0, "timeout", W'(n), W'(max_cycles));
        step();
    endtask

    initial begin
        logic [W-1:0] x;
        int g3, g0b, n0, n3, n;
        for (int a = 0; a < (1 << AW); a++) ref_mem[a] = '0;
        for (int k = 0; k < N; k++) begin
            issued[k] = 0;
            granted[k] = 0;
            waitc[k] = 0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check(sram_address == '0, "reset_address", W'(sram_address), '0);
        check(sram_byteena == '0, "reset_byteena", W'(sram_byteena), '0);
        check(sram_data == '0, "reset_data", sram_data, '0);
        check(busy == 1'b0, "reset_busy", W'(busy), '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Preload every address used later so reads never see unwritten words.
        for (int a = 0; a < 24; a++) push_cmd(a % N, 1, a, '1, rand_word());
        run(200);

        // Single read.
        push_cmd(0, 1, 5, '1, {64{8'hA5}});
        run(50);
        push_cmd(2, 0, 5, '0, '0);
        run(50);
        check(last_rdata == {64{8'hA5}}, "single_read_data", last_rdata, {64{8'hA5}});
        check(last_rsp_valid == 4'b0100, "single_read_owner", W'(last_rsp_valid), W'(4'b0100));

        // Fairness: all four continuously valid, starting from ptr = 0.
        push_cmd(3, 0, 3, '0, '0);
        run(50);
        gseq.delete();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < N; k++) push_cmd(k, 0, k, '0, '0);
        run(100);
        check(gseq.size() == 16, "fair_count", W'(gseq.size()), W'(16));
        for (int i = 0; i < gseq.size() && i < 16; i++)
            check(gseq[i] == i % N, "fair_order", W'(gseq[i]), W'(i % N));

        // Byte-enable write.
        push_cmd(0, 1, 7, '1, {64{8'h11}});
        run(50);
        push_cmd(1, 1, 7, 64'h1, {64{8'hFF}});
        run(50);
        push_cmd(2, 0, 7, '0, '0);
        run(50);
        check(last_rdata == {{63{8'h11}}, 8'hFF}, "byteena_data", last_rdata, {{63{8'h11}}, 8'hFF});

        // Read-after-write on consecutive grants.
        push_cmd(3, 0, 3, '0, '0);
        run(50);
        x = rand_word();
        push_cmd(0, 1, 9, '1, x);
        push_cmd(1, 0, 9, '0, '0);
        run(50);
        check(last_rdata == x, "raw_data", last_rdata, x);

        // Hold stability: requester 3 against a continuously valid requester 0.
        push_cmd(3, 0, 3, '0, '0);
        run(50);
        g3 = granted[3];
        for (int i = 0; i < 6; i++) push_cmd(0, 0, $urandom_range(0, 15), '0, '0);
        push_cmd(3, 0, 20, '0, '0);
        run(100);
        check(granted[3] - g3 == 1, "hold_single_grant", W'(granted[3] - g3), W'(1));

        // Reset with reads from requesters 0 and 3 in flight.
        n0 = granted[0];
        n3 = granted[3];
        push_cmd(0, 0, 1, '0, '0);
        push_cmd(3, 0, 2, '0, '0);
        n = 0;
        do begin
            step();
            n++;
        end while (!(granted[0] > n0 && granted[3] > n3) && n < 20);
        check(granted[0] > n0 && granted[3] > n3, "midflight_grants", W'(n), W'(20));
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check(rsp_valid == '0, "post_reset_rsp", W'(rsp_valid), '0);
        check(sram_address == '0, "post_reset_address", W'(sram_address), '0);
        check(sram_byteena == '0, "post_reset_byteena", W'(sram_byteena), '0);
        check(sram_data == '0, "post_reset_data", sram_data, '0);
        check(!sram_rden && !sram_wren, "post_reset_strobes", W'({sram_rden, sram_wren}), '0);
        check(busy == 1'b0, "post_reset_busy", W'(busy), '0);
        gseq.delete();
        g0b = granted[0];
        for (int k = N - 1; k >= 0; k--) push_cmd(k, 0, k + 10, '0, '0);
        run(50);
        check(gseq.size() > 0 && gseq[0] == 0, "post_reset_first_grant",
              W'(gseq.size() > 0 ? gseq[0] : -1), '0);
        check(granted[0] - g0b == 1, "post_reset_r0_grant", W'(granted[0] - g0b), W'(1));

        // Randomized mix with idle gaps and address collisions.
        gaps = 1;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 12; i++) begin
                if ($urandom_range(0, 1) != 0)
                    push_cmd(k, 1, $urandom_range(0, 15), NB'({$urandom(), $urandom()}), rand_word());
                else
                    push_cmd(k, 0, $urandom_range(0, 15), '0, '0);
            end
        run(3000);
        gaps = 0;

        for (int k = 0; k < N; k++)
            check(granted[k] == issued[k], "grant_total", W'(granted[k]), W'(issued[k]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
